// File: rtl/mux_share_if.sv
// Handshake and data bundle between two requesters and the shared 2:1 mux arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface mux_share_if #(
    parameter int DATA_W = 1
) ();
    logic              req0;
    logic              req1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic              gnt0;
    logic              gnt1;
    logic              sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    modport master (
        output req0, req1, done0, done1, din0, din1,
        input  gnt0, gnt1, sel, dout, dout_valid
    );

    modport slave (
        input  req0, req1, done0, done1, din0, din1,
        output gnt0, gnt1, sel, dout, dout_valid
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux.
// One requester is granted at a time, each tenure is capped at MAX_HOLD cycles
// while the other side is waiting, and the selected data is registered with a
// valid flag that lags the grant by one cycle.
module mux_share_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_share_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t            state_r;
    state_t            state_next_s;
    state_t            arb_s;
    logic              last_r;
    logic              last_next_s;
    logic [7:0]        hcnt_r;
    logic [7:0]        hcnt_next_s;
    logic              hold_full_s;
    logic              release_s;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;

    // Next owner from the live requests; on a tie the requester that is not
    // `lst` wins. Passing the releasing requester as `lst` lets the other side
    // win ties at handover.
    function automatic state_t arbitrate(input logic r0, input logic r1, input logic lst);
        state_t res;
        if (r0 && r1) begin
            res = lst ? GRANT0 : GRANT1;
        end else if (r0) begin
            res = GRANT0;
        end else if (r1) begin
            res = GRANT1;
        end else begin
            res = IDLE;
        end
        return res;
    endfunction

    assign hold_full_s = (hcnt_r == MAX_HOLD_C);

    // Next-state, last-owner and tenure-counter decision.
    always_comb begin
        state_next_s = state_r;
        last_next_s  = last_r;
        hcnt_next_s  = hcnt_r;
        arb_s        = IDLE;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                arb_s        = arbitrate(bus.req0, bus.req1, last_r);
                state_next_s = arb_s;
                if (arb_s != IDLE) begin
                    hcnt_next_s = 8'd1;
                end else begin
                    hcnt_next_s = 8'd0;
                end
            end
            GRANT0: begin
                release_s = !bus.req0 || bus.done0 || (hold_full_s && bus.req1);
                if (release_s) begin
                    last_next_s  = 1'b0;
                    arb_s        = arbitrate(bus.req0, bus.req1, 1'b0);
                    state_next_s = arb_s;
                    if (arb_s != IDLE) begin
                        hcnt_next_s = 8'd1;
                    end else begin
                        hcnt_next_s = 8'd0;
                    end
                end else if (hold_full_s) begin
                    // Nobody waiting: renew the tenure instead of idling.
                    hcnt_next_s = 8'd1;
                end else begin
                    hcnt_next_s = hcnt_r + 8'd1;
                end
            end
            GRANT1: begin
                release_s = !bus.req1 || bus.done1 || (hold_full_s && bus.req0);
                if (release_s) begin
                    last_next_s  = 1'b1;
                    arb_s        = arbitrate(bus.req0, bus.req1, 1'b1);
                    state_next_s = arb_s;
                    if (arb_s != IDLE) begin
                        hcnt_next_s = 8'd1;
                    end else begin
                        hcnt_next_s = 8'd0;
                    end
                end else if (hold_full_s) begin
                    hcnt_next_s = 8'd1;
                end else begin
                    hcnt_next_s = hcnt_r + 8'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                hcnt_next_s  = 8'd0;
            end
        endcase
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            hcnt_r  <= 8'd0;
        end else begin
            state_r <= state_next_s;
            last_r  <= last_next_s;
            hcnt_r  <= hcnt_next_s;
        end
    end

    // Register the mux output while a grant is active; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= (state_r != IDLE);
            if (state_r == GRANT1) begin
                dout_r <= bus.din1;
            end else if (state_r == GRANT0) begin
                dout_r <= bus.din0;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign bus.gnt0       = (state_r == GRANT0);
    assign bus.gnt1       = (state_r == GRANT1);
    assign bus.sel        = (state_r == GRANT1);
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized and directed bench for mux_share_arbiter. Two instances
// (MAX_HOLD 8 and 4) share the same stimulus and are each compared every
// cycle against a cycle-level ownership model.
module tb_mux_share_arbiter;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    logic r0, r1, dn0, dn1;
    logic [DW-1:0] a, b;

    int n_checks = 0;
    int n_errors = 0;

    mux_share_if #(.DATA_W(DW)) bus8 ();
    mux_share_if #(.DATA_W(DW)) bus4 ();

    assign bus8.req0 = r0;  assign bus8.req1 = r1;
    assign bus8.done0 = dn0; assign bus8.done1 = dn1;
    assign bus8.din0 = a;   assign bus8.din1 = b;
    assign bus4.req0 = r0;  assign bus4.req1 = r1;
    assign bus4.done0 = dn0; assign bus4.done1 = dn1;
    assign bus4.din0 = a;   assign bus4.din1 = b;

    mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Reference model: owner -1 = nobody, 0/1 = requester; cnt = cycles in tenure.
    int          m_own  [2];
    int          m_last [2];
    int          m_cnt  [2];
    int          m_hold [2];
    logic [DW-1:0] m_dout [2];
    logic        m_dv   [2];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic q0, input logic q1, input int lst);
        if (q0 && q1) return (lst == 0) ? 1 : 0;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic model_edge(input int k);
        logic mine, other, fin;
        if (m_own[k] >= 0) begin
            m_dout[k] = (m_own[k] == 1) ? b : a;
        end
        m_dv[k] = (m_own[k] >= 0);
        if (rst) begin
            m_own[k] = -1; m_last[k] = 1; m_cnt[k] = 0;
            m_dout[k] = '0; m_dv[k] = 1'b0;
        end else if (m_own[k] < 0) begin
            m_own[k] = pick(r0, r1, m_last[k]);
            m_cnt[k] = (m_own[k] >= 0) ? 1 : 0;
        end else begin
            mine  = (m_own[k] == 1) ? r1 : r0;
            other = (m_own[k] == 1) ? r0 : r1;
            fin   = (m_own[k] == 1) ? dn1 : dn0;
            if (!mine || fin || (m_cnt[k] == m_hold[k] && other)) begin
                m_last[k] = m_own[k];
                m_own[k]  = pick(r0, r1, m_own[k]);
                m_cnt[k]  = (m_own[k] >= 0) ? 1 : 0;
            end else begin
                m_cnt[k] = (m_cnt[k] == m_hold[k]) ? 1 : m_cnt[k] + 1;
            end
        end
    endtask

    task automatic check_dut(input string nm, input int k, input logic g0, input logic g1,
                             input logic s, input logic [DW-1:0] d, input logic dv);
        check_value({nm, ".gnt0"}, 32'(g0), 32'(m_own[k] == 0));
        check_value({nm, ".gnt1"}, 32'(g1), 32'(m_own[k] == 1));
        check_value({nm, ".sel"},  32'(s),  32'(m_own[k] == 1));
        check_value({nm, ".dout"}, 32'(d),  32'(m_dout[k]));
        check_value({nm, ".dout_valid"}, 32'(dv), 32'(m_dv[k]));
        check_value({nm, ".excl"}, 32'(g0 & g1), 32'd0);
    endtask

    task automatic step(input logic rs, input logic q0, input logic q1, input logic e0,
                        input logic e1, input logic [DW-1:0] x0, input logic [DW-1:0] x1);
        rst = rs; r0 = q0; r1 = q1; dn0 = e0; dn1 = e1; a = x0; b = x1;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_dut("d8", 0, bus8.gnt0, bus8.gnt1, bus8.sel, bus8.dout, bus8.dout_valid);
        check_dut("d4", 1, bus4.gnt0, bus4.gnt1, bus4.sel, bus4.dout, bus4.dout_valid);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        m_hold[0] = 8; m_hold[1] = 4;
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_last[k] = 1; m_cnt[k] = 0; m_dout[k] = '0; m_dv[k] = 1'b0;
        end
        rst = 1'b1; r0 = 1'b0; r1 = 1'b0; dn0 = 1'b0; dn1 = 1'b0; a = '0; b = '0;

        // Reset, then a single held request on side 0.
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0);

        // Simultaneous first request: alternation every MAX_HOLD cycles.
        do_reset(1);
        for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5);

        // Early release of GRANT1 in its third cycle with req0 waiting.
        do_reset(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'hC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'hC);

        // Hold renewal: only req1, din1 toggling against an opposite din0.
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] v;
            v = (i % 2 == 0) ? 4'h1 : 4'h0;
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ~v, v);
        end

        // Reset in the second cycle of GRANT0 with both requests high.
        do_reset(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'h8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'h8);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'h8);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'h9);

        // Request withdrawal: req0 pulses during GRANT1, then GRANT1 ends.
        do_reset(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'hD);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'hD);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'hD);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'hD);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'hD);

        // Random traffic, including rare resets and occasional done pulses.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 100) == 0,
                 ($urandom % 4) != 0,
                 ($urandom % 4) != 0,
                 ($urandom % 8) == 0,
                 ($urandom % 8) == 0,
                 DW'($urandom), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
